tx_rx_fifo_control: RTL and testbench

//  Parametrised successor to the single-register UART TX/RX control stage.

---
 rtl/tx_rx_fifo_control_if.sv | 41 ++++
 rtl/tx_rx_fifo_control.sv | 153 +++++++++++++++
 tb/tb_tx_rx_fifo_control.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_rx_fifo_control_if.sv
// Signal bundle between the UART register file / shifters and tx_rx_fifo_control.
// The slave modport is the FIFO control block; master is whoever drives the host and shifter side.
interface tx_rx_fifo_control_if #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(RX_DEPTH) + 1;

    logic [1:0]         word_length;
    logic [2:0]         parity;
    logic [1:0]         fifo_clr;
    logic [DATA_W:0]    pi_rx_data;
    logic               pi_rx_flag;
    logic               read_flag;
    logic [DATA_W-1:0]  pi_tx_data;
    logic               write_flag;
    logic               pi_tx_flag;
    logic [DATA_W-1:0]  po_rx_data;
    logic               parity_error;
    logic               data_ready;
    logic               overrun_error;
    logic [LEVEL_W-1:0] rx_level;
    logic [DATA_W:0]    po_tx_data;
    logic               po_tx_flag;
    logic               thr_empty;
    logic               tx_empty;

    modport master (
        output word_length, parity, fifo_clr, pi_rx_data, pi_rx_flag, read_flag,
               pi_tx_data, write_flag, pi_tx_flag,
        input  po_rx_data, parity_error, data_ready, overrun_error, rx_level,
               po_tx_data, po_tx_flag, thr_empty, tx_empty
    );

    modport slave (
        input  word_length, parity, fifo_clr, pi_rx_data, pi_rx_flag, read_flag,
               pi_tx_data, write_flag, pi_tx_flag,
        output po_rx_data, parity_error, data_ready, overrun_error, rx_level,
               po_tx_data, po_tx_flag, thr_empty, tx_empty
    );
endinterface

// File: rtl/tx_rx_fifo_control.sv
// UART RX/TX FIFO control: buffers received and host-written characters, checks and
// generates parity, and hands TX characters to the shifter one at a time.
module tx_rx_fifo_control #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input logic clk,
    input logic rst,
    tx_rx_fifo_control_if.slave bus
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic {IDLE, WAIT} tx_state_t;

    function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] wl);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++)
            if (i < 5 + int'(wl)) m[i] = d[i];
        return m;
    endfunction

    // Parity bit a correct sender would append; stick mode ignores the data entirely.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [2:0] par);
        if (par[2]) return ~par[1];
        return par[1] ? ^d : ~^d;
    endfunction

    logic [DATA_W:0]   rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]    rx_count;
    logic              rx_clr, rx_empty, rx_full, rx_pop, rx_push, overrun;
    logic [DATA_W-1:0] rx_masked;
    logic              rx_perr;

    assign rx_clr    = bus.fifo_clr[0];
    assign rx_empty  = (rx_count == '0);
    assign rx_full   = (rx_count == RX_FULL_LVL);
    assign rx_pop    = bus.read_flag & ~rx_empty & ~rx_clr;
    assign rx_push   = bus.pi_rx_flag & (~rx_full | rx_pop) & ~rx_clr;
    assign rx_masked = mask_data(bus.pi_rx_data[DATA_W-1:0], bus.word_length);
    assign rx_perr   = bus.parity[0] &
                       (bus.pi_rx_data[DATA_W] != parity_bit(rx_masked, bus.parity));

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= {rx_perr, rx_masked};
    end

    // A push that finds the FIFO full without a same-edge pop is lost and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
        end else if (rx_clr) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RX_AW+1)'(1);
            else if (rx_pop && !rx_push) rx_count <= rx_count - (RX_AW+1)'(1);
            if (bus.pi_rx_flag && !rx_push) overrun <= 1'b1;
            else if (bus.read_flag)         overrun <= 1'b0;
        end
    end

    assign bus.po_rx_data    = rx_empty ? '0 : rx_mem[rx_rd_ptr][DATA_W-1:0];
    assign bus.parity_error  = ~rx_empty & rx_mem[rx_rd_ptr][DATA_W];
    assign bus.data_ready    = ~rx_empty;
    assign bus.overrun_error = overrun;
    assign bus.rx_level      = rx_count;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]    tx_count;
    logic              tx_clr, tx_fifo_empty, tx_full, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_masked;
    logic [DATA_W:0]   tx_launch, tx_data_q;
    logic              tx_flag_q;
    tx_state_t         tx_state, tx_next;

    assign tx_clr        = bus.fifo_clr[1];
    assign tx_fifo_empty = (tx_count == '0);
    assign tx_full       = (tx_count == TX_FULL_LVL);
    assign tx_push       = bus.write_flag & ~tx_full & ~tx_clr;
    assign tx_masked     = mask_data(tx_mem[tx_rd_ptr], bus.word_length);
    assign tx_launch     = {bus.parity[0] & parity_bit(tx_masked, bus.parity), tx_masked};

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.pi_tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_clr) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (TX_AW+1)'(1);
            else if (tx_pop && !tx_push) tx_count <= tx_count - (TX_AW+1)'(1);
        end
    end

    // Clearing the TX FIFO suppresses a pop, but a character already in WAIT runs to completion.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!tx_fifo_empty && !tx_clr) begin
                    tx_pop  = 1'b1;
                    tx_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.pi_tx_flag) tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= IDLE;
            tx_data_q <= '0;
            tx_flag_q <= 1'b0;
        end else begin
            tx_state  <= tx_next;
            tx_flag_q <= tx_pop;
            if (tx_pop) tx_data_q <= tx_launch;
        end
    end

    assign bus.po_tx_data = tx_data_q;
    assign bus.po_tx_flag = tx_flag_q;
    assign bus.thr_empty  = tx_fifo_empty;
    assign bus.tx_empty   = tx_fifo_empty & (tx_state == IDLE);
endmodule

// File: tb/tb_tx_rx_fifo_control.sv
// Self-checking bench for tx_rx_fifo_control: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_tx_rx_fifo_control;
    localparam int DATA_W   = 8;
    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   launches   = 0;

    logic [8:0] m_rx_q[$];
    logic [7:0] m_tx_q[$];
    bit         m_ovr, m_busy, m_flag;
    logic [8:0] m_tx_data;

    tx_rx_fifo_control_if #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH)) bus ();

    tx_rx_fifo_control #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mdlMask(input logic [7:0] d, input logic [1:0] wl);
        int w;
        w = int'(wl) + 5;
        return d & 8'((1 << w) - 1);
    endfunction

    function automatic logic mdlParity(input logic [7:0] d, input logic [2:0] par);
        if (par[2]) return !par[1];
        if (par[1]) return ($countones(d) % 2) == 1;
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        logic [8:0] head;
        head = (m_rx_q.size() > 0) ? m_rx_q[0] : 9'h000;
        checkOutput("po_rx_data", 32'(bus.po_rx_data), 32'(head[7:0]));
        checkOutput("parity_error", 32'(bus.parity_error), 32'(head[8]));
        checkOutput("data_ready", 32'(bus.data_ready), 32'(m_rx_q.size() > 0));
        checkOutput("overrun_error", 32'(bus.overrun_error), 32'(m_ovr));
        checkOutput("rx_level", 32'(bus.rx_level), 32'(m_rx_q.size()));
        checkOutput("po_tx_flag", 32'(bus.po_tx_flag), 32'(m_flag));
        checkOutput("po_tx_data", 32'(bus.po_tx_data), 32'(m_tx_data));
        checkOutput("thr_empty", 32'(bus.thr_empty), 32'(m_tx_q.size() == 0));
        checkOutput("tx_empty", 32'(bus.tx_empty), 32'(m_tx_q.size() == 0 && !m_busy));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_po_rx_data"}, 32'(bus.po_rx_data), 32'(0));
        checkOutput({tag, "_parity_error"}, 32'(bus.parity_error), 32'(0));
        checkOutput({tag, "_data_ready"}, 32'(bus.data_ready), 32'(0));
        checkOutput({tag, "_overrun"}, 32'(bus.overrun_error), 32'(0));
        checkOutput({tag, "_rx_level"}, 32'(bus.rx_level), 32'(0));
        checkOutput({tag, "_po_tx_data"}, 32'(bus.po_tx_data), 32'(0));
        checkOutput({tag, "_po_tx_flag"}, 32'(bus.po_tx_flag), 32'(0));
        checkOutput({tag, "_thr_empty"}, 32'(bus.thr_empty), 32'(1));
        checkOutput({tag, "_tx_empty"}, 32'(bus.tx_empty), 32'(1));
    endtask

    task automatic modelReset();
        m_rx_q.delete();
        m_tx_q.delete();
        m_ovr     = 1'b0;
        m_busy    = 1'b0;
        m_flag    = 1'b0;
        m_tx_data = '0;
    endtask

    // Advances the reference model across one clock edge using the inputs seen at that edge.
    task automatic modelStep(input logic rxf, input logic [8:0] rxd, input logic rd,
                             input logic wr, input logic [7:0] txd, input logic txdone,
                             input logic [1:0] clr);
        bit         rx_pop, rx_ok, tx_full_before;
        logic [7:0] d;
        logic [2:0] par;
        par = bus.parity;
        if (clr[0]) begin
            m_rx_q.delete();
            m_ovr = 1'b0;
        end else begin
            rx_pop = rd && (m_rx_q.size() > 0);
            rx_ok  = rxf && ((m_rx_q.size() < RX_DEPTH) || rx_pop);
            if (rx_pop) void'(m_rx_q.pop_front());
            if (rx_ok) begin
                d = mdlMask(rxd[7:0], bus.word_length);
                m_rx_q.push_back({par[0] && (rxd[8] != mdlParity(d, par)), d});
            end
            if (rxf && !rx_ok) m_ovr = 1'b1;
            else if (rd)       m_ovr = 1'b0;
        end
        m_flag = 1'b0;
        tx_full_before = (m_tx_q.size() == TX_DEPTH);
        if (!m_busy) begin
            if (m_tx_q.size() > 0 && !clr[1]) begin
                d = mdlMask(m_tx_q.pop_front(), bus.word_length);
                m_tx_data = {par[0] ? mdlParity(d, par) : 1'b0, d};
                m_flag = 1'b1;
                m_busy = 1'b1;
            end
        end else if (txdone) begin
            m_busy = 1'b0;
        end
        if (clr[1])                      m_tx_q.delete();
        else if (wr && !tx_full_before)  m_tx_q.push_back(txd);
    endtask

    task automatic applyStimulus(input logic rxf, input logic [8:0] rxd, input logic rd,
                                 input logic wr, input logic [7:0] txd, input logic txdone,
                                 input logic [1:0] clr);
        bus.pi_rx_flag = rxf;
        bus.pi_rx_data = rxd;
        bus.read_flag  = rd;
        bus.write_flag = wr;
        bus.pi_tx_data = txd;
        bus.pi_tx_flag = txdone;
        bus.fifo_clr   = clr;
        @(posedge clk);
        modelStep(rxf, rxd, rd, wr, txd, txdone, clr);
        #1;
        checkAll();
        if (bus.po_tx_flag === 1'b1) launches++;
        bus.pi_rx_flag = 1'b0;
        bus.read_flag  = 1'b0;
        bus.write_flag = 1'b0;
        bus.pi_tx_flag = 1'b0;
        bus.fifo_clr   = 2'b00;
    endtask

    task automatic idle();                     applyStimulus(0, '0, 0, 0, '0, 0, 2'b00); endtask
    task automatic rxPush(input logic [8:0] d); applyStimulus(1, d, 0, 0, '0, 0, 2'b00); endtask
    task automatic hostRead();                 applyStimulus(0, '0, 1, 0, '0, 0, 2'b00); endtask
    task automatic hostWrite(input logic [7:0] d); applyStimulus(0, '0, 0, 1, d, 0, 2'b00); endtask
    task automatic txDone();                   applyStimulus(0, '0, 0, 0, '0, 1, 2'b00); endtask

    // One complete TX character with an empty FIFO: launch timing, pulse width and tx_empty.
    task automatic sendTx(input logic [7:0] d, output logic [8:0] launched);
        int wait_cycles;
        wait_cycles = -1;
        launched    = '0;
        hostWrite(d);
        checkOutput("tx_empty_after_write", 32'(bus.tx_empty), 32'(0));
        for (int i = 0; i < 8 && wait_cycles < 0; i++) begin
            idle();
            if (bus.po_tx_flag === 1'b1) begin
                wait_cycles = i;
                launched    = bus.po_tx_data;
            end
        end
        checkOutput("tx_launch_latency", 32'(wait_cycles), 32'(0));
        idle();
        checkOutput("tx_flag_one_cycle", 32'(bus.po_tx_flag), 32'(0));
        checkOutput("tx_empty_in_wait", 32'(bus.tx_empty), 32'(0));
        txDone();
        checkOutput("tx_empty_after_done", 32'(bus.tx_empty), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [8:0] launched;
        int         done_count;

        rst             = 1'b1;
        bus.word_length = 2'b11;
        bus.parity      = 3'b001;
        bus.fifo_clr    = 2'b00;
        bus.pi_rx_data  = '0;
        bus.pi_rx_flag  = 1'b0;
        bus.read_flag   = 1'b0;
        bus.pi_tx_data  = '0;
        bus.write_flag  = 1'b0;
        bus.pi_tx_flag  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        idle();

        rxPush(9'h17F);
        checkOutput("rx17F_data", 32'(bus.po_rx_data), 32'h7F);
        checkOutput("rx17F_perr", 32'(bus.parity_error), 32'(1));
        checkOutput("rx17F_ready", 32'(bus.data_ready), 32'(1));
        hostRead();
        checkOutput("rx17F_ready_after_read", 32'(bus.data_ready), 32'(0));
        hostRead();

        sendTx(8'hFF, launched);
        checkOutput("txFF_odd_data", 32'(launched), 32'h1FF);

        bus.word_length = 2'b00;
        bus.parity      = 3'b011;
        sendTx(8'hFF, launched);
        checkOutput("txFF_wl5_even", 32'(launched), 32'h11F);
        rxPush(9'h11F);
        checkOutput("rx11F_perr", 32'(bus.parity_error), 32'(0));
        checkOutput("rx11F_data", 32'(bus.po_rx_data), 32'h1F);
        hostRead();

        bus.word_length = 2'b11;
        bus.parity      = 3'b101;
        rxPush(9'h0AA);
        checkOutput("stick1_perr", 32'(bus.parity_error), 32'(1));
        hostRead();
        bus.parity = 3'b111;
        sendTx(8'h01, launched);
        checkOutput("stick0_txbit", 32'(launched[8]), 32'(0));

        bus.parity = 3'b000;
        applyStimulus(0, '0, 0, 0, '0, 0, 2'b01);
        for (int i = 0; i < RX_DEPTH; i++) rxPush(9'(8'h30 + i));
        rxPush(9'h0EE);
        checkOutput("ovr_set", 32'(bus.overrun_error), 32'(1));
        checkOutput("ovr_level", 32'(bus.rx_level), 32'(16));
        checkOutput("ovr_head", 32'(bus.po_rx_data), 32'h30);
        for (int i = 0; i < RX_DEPTH; i++) begin
            checkOutput("ovr_drain_head", 32'(bus.po_rx_data), 32'(8'h30 + i));
            hostRead();
            if (i == 0) checkOutput("ovr_clear_on_read", 32'(bus.overrun_error), 32'(0));
        end
        checkOutput("ovr_drained", 32'(bus.data_ready), 32'(0));

        for (int i = 0; i < RX_DEPTH; i++) rxPush(9'(8'h40 + i));
        applyStimulus(1, 9'h055, 1, 0, '0, 0, 2'b00);
        checkOutput("full_push_read_level", 32'(bus.rx_level), 32'(16));
        checkOutput("full_push_read_ovr", 32'(bus.overrun_error), 32'(0));
        applyStimulus(1, 9'h066, 1, 0, '0, 0, 2'b01);
        checkOutput("rx_clear_level", 32'(bus.rx_level), 32'(0));

        launched   = '0;
        done_count = launches;
        hostWrite(8'h11);
        hostWrite(8'h22);
        hostWrite(8'h33);
        for (int i = 0; i < 30; i++) begin
            if (launches > done_count) begin
                txDone();
                done_count++;
            end else begin
                idle();
            end
        end
        checkOutput("tx_three_launches", 32'(done_count - (launches - 3)), 32'(3));
        checkOutput("tx_three_idle", 32'(bus.tx_empty), 32'(1));

        rxPush(9'h001);
        for (int i = 0; i < 40; i++) applyStimulus(1, 9'($urandom_range(255)), 1, 0, '0, 0, 2'b00);
        checkOutput("wrap_level", 32'(bus.rx_level), 32'(1));
        hostRead();

        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                bus.word_length = 2'($urandom_range(3));
                bus.parity      = 3'($urandom_range(7));
            end
            applyStimulus($urandom_range(99) < 40, 9'($urandom), $urandom_range(99) < 35,
                          $urandom_range(99) < 40, 8'($urandom), $urandom_range(99) < 30,
                          {$urandom_range(99) < 2, $urandom_range(99) < 2});
        end

        rxPush(9'h0A5);
        rxPush(9'h05A);
        hostWrite(8'h77);
        hostWrite(8'h88);
        idle();
        #2 rst = 1'b1;
        #1;
        checkReset("midreset");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();
        rxPush(9'h012);
        hostRead();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
